// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer
//
// Pops words from a synchronous FIFO one at a time and shifts each one out, one bit per
// accepted beat, on a valid/ready serial interface with first/last framing. A saturating
// counter of completed words is kept for the scoreboard.
//
// Optional feature: define SER_PARITY_EN to append one even-parity beat (XOR of all data
// bits) after the data beats; ser_last then moves onto the parity beat.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   enable             permits new pops, sampled in IDLE only
//   fifo_empty         FIFO empty flag, sampled in IDLE only
//   fifo_dout          FIFO read data, valid the cycle after fifo_rd_en is sampled
//   fifo_rd_en         one-cycle read pulse per word
//   ser_ready          sink accepts the current beat
//   ser_valid          current beat is valid
//   ser_data           serial bit
//   ser_first/last     framing flags on the first/last beat of a word
//   busy               high in any state other than IDLE
//   words_sent         completed words, saturating at all-ones
module fifo_rd_serializer #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  ser_ready,
  output logic                  ser_valid,
  output logic                  ser_data,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  // Wide enough to count the parity beat as well.
  localparam int unsigned CntBits = $clog2(FIFO_WIDTH + 1);

`ifdef SER_PARITY_EN
  localparam logic [CntBits-1:0] BeatLast = CntBits'(FIFO_WIDTH);
`else
  localparam logic [CntBits-1:0] BeatLast = CntBits'(FIFO_WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StLoad,
    StShift
  } state_e;

  state_e                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  data_q, data_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [FIFO_WIDTH-1:0] shift_q, shift_d;
  logic [CntBits-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
`ifdef SER_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic [FIFO_WIDTH-1:0] shift_nxt;
  logic [CntBits-1:0]    cnt_inc;

  // Bit presented on the wire for a given shift-register value.
  function automatic logic head_bit(input logic [FIFO_WIDTH-1:0] v);
    return MSB_FIRST ? v[FIFO_WIDTH-1] : v[0];
  endfunction

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    valid_d   = valid_q;
    busy_d    = busy_q;
    data_d    = data_q;
    first_d   = first_q;
    last_d    = last_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
`ifdef SER_PARITY_EN
    parity_d  = parity_q;
`endif
    shift_nxt = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    cnt_inc   = cnt_q + CntBits'(1);

    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          state_d = StPop;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        // The FIFO updated fifo_dout on the edge that sampled rd_en, so it is valid now.
        state_d = StShift;
        shift_d = fifo_dout;
        cnt_d   = '0;
        valid_d = 1'b1;
        first_d = 1'b1;
        last_d  = (BeatLast == '0);
        data_d  = head_bit(fifo_dout);
`ifdef SER_PARITY_EN
        parity_d = ^fifo_dout;
`endif
      end
      StShift: begin
        // valid is always high here, so ready alone qualifies a transfer.
        if (ser_ready) begin
          if (cnt_q == BeatLast) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            data_d  = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            shift_d = '0;
            if (words_q != '1) begin
              words_d = words_q + CNT_WIDTH'(1);
            end
          end else begin
            shift_d = shift_nxt;
            cnt_d   = cnt_inc;
            first_d = 1'b0;
            last_d  = (cnt_inc == BeatLast);
`ifdef SER_PARITY_EN
            data_d  = (cnt_inc == BeatLast) ? parity_q : head_bit(shift_nxt);
`else
            data_d  = head_bit(shift_nxt);
`endif
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      first_q  <= first_d;
      last_q   <= last_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign ser_valid  = valid_q;
  assign ser_data   = data_q;
  assign ser_first  = first_q;
  assign ser_last   = last_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
`timescale 1ns/1ps
module tb_fifo_rd_serializer;

  localparam int W = 16;
`ifdef SER_PARITY_EN
  localparam int NB        = 17;
  localparam int SpanTog   = 33;
`else
  localparam int NB        = 16;
  localparam int SpanTog   = 31;
`endif
  localparam logic [NB-1:0] FirstMask = NB'(1);
  localparam logic [NB-1:0] LastMask  = {1'b1, {(NB-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic         fifo_rd_en;
  logic         ser_ready;
  logic         ser_valid;
  logic         ser_data;
  logic         ser_first;
  logic         ser_last;
  logic         busy;
  logic [15:0]  words_sent;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_serializer #(
    .FIFO_WIDTH(W),
    .MSB_FIRST (1'b1),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy),
    .words_sent(words_sent)
  );

  // Simple FIFO model: registered read data, updated on the edge that samples rd_en.
  logic [W-1:0] mem [64];
  int  wr_ptr    = 0;
  int  rd_ptr    = 0;
  int  rd_pulses = 0;
  bit  rd_prev   = 1'b0;
  bit  rd_double = 1'b0;
  bit  underflow = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses <= rd_pulses + 1;
      if (fifo_empty) underflow <= 1'b1;
      if (rd_prev)    rd_double <= 1'b1;
    end
    rd_prev <= fifo_rd_en;
  end

  task automatic push(input logic [W-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Collects one word from the serial port. Beat i lands in bit i of the outputs.
  // toggle: ready = 1,0,1,0... starting on the first valid cycle.
  // drop_at: beat index on whose transfer enable is dropped (-1 = never).
  task automatic recv_word(input bit toggle, input int drop_at,
                           output logic [NB-1:0] bits, output logic [NB-1:0] firsts,
                           output logic [NB-1:0] lasts, output int span, output int pre,
                           output bit hold_bad, output bit tmo);
    int         beat;
    int         cyc;
    bit         started;
    logic       prev_rdy;
    logic [3:0] prev;
    beat = 0; cyc = 0; started = 1'b0; prev_rdy = 1'b1; prev = '0;
    bits = '0; firsts = '0; lasts = '0; span = 0; pre = 0; hold_bad = 1'b0; tmo = 1'b0;
    while (beat < NB) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        tmo = 1'b1;
        break;
      end
      if (!started && ser_valid) started = 1'b1;
      if (!started) begin
        pre++;
        ser_ready = 1'b1;
      end else begin
        span++;
        if (!prev_rdy && ({ser_valid, ser_data, ser_first, ser_last} != prev)) hold_bad = 1'b1;
        ser_ready = toggle ? ((span % 2) == 1) : 1'b1;
        if (ser_valid && ser_ready) begin
          bits[beat]   = ser_data;
          firsts[beat] = ser_first;
          lasts[beat]  = ser_last;
          if (beat == drop_at) enable = 1'b0;
          beat++;
        end
        prev_rdy = ser_ready;
        prev     = {ser_valid, ser_data, ser_first, ser_last};
      end
    end
    ser_ready = 1'b1;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] beats;  // expected serial stream, beat 0 in bit 0
    logic        par;
    bit          toggle;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [NB-1:0] bits, firsts, lasts;
    int            span, pre, p0, n, cyc, exp_words;
    bit            hold_bad, tmo;

    vecs[0] = '{word: 16'hA5C3, beats: 16'hC3A5, par: 1'b0, toggle: 1'b0};
    vecs[1] = '{word: 16'h8000, beats: 16'h0001, par: 1'b1, toggle: 1'b1};
    vecs[2] = '{word: 16'h0001, beats: 16'h8000, par: 1'b1, toggle: 1'b0};
    vecs[3] = '{word: 16'hFFFF, beats: 16'hFFFF, par: 1'b0, toggle: 1'b1};
    vecs[4] = '{word: 16'h0007, beats: 16'hE000, par: 1'b1, toggle: 1'b0};
    vecs[5] = '{word: 16'h0003, beats: 16'hC000, par: 1'b0, toggle: 1'b0};
    vecs[6] = '{word: 16'h1234, beats: 16'h2C48, par: 1'b1, toggle: 1'b1};

    exp_words = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    ser_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Empty FIFO: no pops.
    p0 = rd_pulses;
    repeat (20) @(negedge clk);
    check("idle_no_pop", rd_pulses - p0, 0);
    check("idle_busy", busy, 0);

    // Asynchronous reset between clock edges.
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", ser_valid, 0);
    check("rst_data", ser_data, 0);
    check("rst_first", ser_first, 0);
    check("rst_last", ser_last, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single words, with and without back-pressure.
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].word);
      recv_word(vecs[i].toggle, -1, bits, firsts, lasts, span, pre, hold_bad, tmo);
      @(negedge clk);
      exp_words++;
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_data", i), bits[15:0], vecs[i].beats);
      check($sformatf("v%0d_first", i), firsts, FirstMask);
      check($sformatf("v%0d_last", i), lasts, LastMask);
      check($sformatf("v%0d_span", i), span, vecs[i].toggle ? SpanTog : NB);
      check($sformatf("v%0d_hold", i), hold_bad, 0);
`ifdef SER_PARITY_EN
      check($sformatf("v%0d_parity", i), bits[NB-1], vecs[i].par);
`endif
      check($sformatf("v%0d_words", i), words_sent, exp_words);
      check($sformatf("v%0d_idle", i), {busy, ser_valid}, 2'b00);
    end

    // Drain eight one-hot words back to back.
    p0 = rd_pulses;
    for (int k = 0; k < 8; k++) push(16'h0001 << k);
    for (int k = 0; k < 8; k++) begin
      recv_word(1'b0, -1, bits, firsts, lasts, span, pre, hold_bad, tmo);
      exp_words++;
      check($sformatf("drain%0d_timeout", k), tmo, 0);
      check($sformatf("drain%0d_data", k), bits[15:0], 16'h8000 >> k);
      check($sformatf("drain%0d_frame", k), {firsts, lasts}, {FirstMask, LastMask});
      if (k > 0) check($sformatf("drain%0d_gap", k), pre, 3);
    end
    repeat (10) @(negedge clk);
    check("drain_pops", rd_pulses - p0, 8);
    check("drain_words", words_sent, exp_words);
    check("drain_idle", {busy, fifo_empty}, 2'b01);

    // Enable dropped mid-word: the word completes, no further pop.
    p0 = rd_pulses;
    push(16'h1234);
    push(16'hA5C3);
    recv_word(1'b0, 3, bits, firsts, lasts, span, pre, hold_bad, tmo);
    exp_words++;
    check("endrop_timeout", tmo, 0);
    check("endrop_data", bits[15:0], 16'h2C48);
    check("endrop_last", lasts, LastMask);
    repeat (20) @(negedge clk);
    check("endrop_pops", rd_pulses - p0, 1);
    check("endrop_halt", {busy, fifo_empty}, 2'b00);
    check("endrop_words", words_sent, exp_words);
    enable = 1'b1;
    recv_word(1'b0, -1, bits, firsts, lasts, span, pre, hold_bad, tmo);
    @(negedge clk);
    exp_words++;
    check("resume_data", bits[15:0], 16'hC3A5);
    check("resume_words", words_sent, exp_words);

    // Reset during beat 7 of 16'hFFFF.
    push(16'hFFFF);
    n = 0;
    cyc = 0;
    while (n < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ser_valid && ser_ready) n++;
    end
    check("abort_reach", n, 7);
    @(negedge clk);
    check("abort_pre_valid", {ser_valid, ser_data}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    exp_words = 0;
    check("abort_valid", ser_valid, 0);
    check("abort_outs", {fifo_rd_en, ser_data, ser_first, ser_last, busy}, 5'b0);
    check("abort_words", words_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0001);
    recv_word(1'b0, -1, bits, firsts, lasts, span, pre, hold_bad, tmo);
    @(negedge clk);
    exp_words++;
    check("after_abort_timeout", tmo, 0);
    check("after_abort_data", bits[15:0], 16'h8000);
    check("after_abort_frame", {firsts, lasts}, {FirstMask, LastMask});
    check("after_abort_words", words_sent, exp_words);

    check("no_underflow", underflow, 0);
    check("no_double_rd_en", rd_double, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
- Downstream consumer of the synchronous FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8).
- Pops one word at a time via the FIFO read port and shifts it out one bit per accepted beat on a valid/ready serial interface, with first/last framing.
- Throttled by an enable input.
- Keeps a saturating count of completed words for the scoreboard.

Parameters:
- FIFO_WIDTH, 16, width of the FIFO word; also the number of serial beats per word.
- MSB_FIRST, 1, 1 = shift out bit FIFO_WIDTH-1 first; 0 = shift out bit 0 first.
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new pops; sampled in IDLE only.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  FIFO_WIDTH  FIFO read data; registered, valid the cycle after rd_en is sampled.
- fifo_rd_en  output  1  FIFO read request, exactly one-cycle pulse per word.
- ser_ready  input  1  sink accepts the current beat.
- ser_valid  output  1  ser_data is valid.
- ser_data  output  1  serial bit.
- ser_first  output  1  high on the first beat of a word.
- ser_last  output  1  high on the last beat of a word (data or parity).
- busy  output  1  high in any state other than IDLE.
- words_sent  output  CNT_WIDTH  completed words; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - fifo_rd_en, ser_valid, ser_data, ser_first, ser_last, busy = 0.
  - Shift register = 0, bit counter = 0, words_sent = 0.
  - Takes effect immediately and mid-word: any word in flight is discarded with no partial completion and no counter increment.
- FSM states: IDLE, POP, LOAD, SHIFT.
- IDLE:
  - If enable=1 and fifo_empty=0 → POP.
  - Otherwise stay in IDLE.
- POP (1 cycle):
  - fifo_rd_en=1 (Moore output, registered) → LOAD.
- LOAD (1 cycle):
  - Capture fifo_dout into the shift register; bit counter = 0 → SHIFT.
  - Sampling this cycle is required because the FIFO updates dout on the edge that samples rd_en.
- SHIFT:
  - ser_valid=1.
  - ser_data = current MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register.
  - ser_first=1 when the bit counter is 0.
  - Beat transfers on ser_valid & ser_ready. Then the register shifts by one and the counter increments.
  - ser_ready=0: hold data, valid and flags unchanged. No timeout.
  - Transfer of the last beat (counter = FIFO_WIDTH-1, or the parity beat when enabled): ser_last=1 on that beat, words_sent++ (saturating) → IDLE.
- Throughput: minimum 3 non-SHIFT cycles between words (IDLE, POP, LOAD). Back-to-back words give 16 valid beats then a 3-cycle gap.
- enable=0 during POP/LOAD/SHIFT does not abort; the current word completes, and the block halts in IDLE.
- fifo_empty is ignored outside IDLE. A pop is only issued when empty=0 was sampled, so underflow is never caused by this block.
- fifo_rd_en is never asserted in two consecutive cycles.
- busy=1 from POP until the last beat transfers.
- Bit counter width: $clog2(FIFO_WIDTH+1) bits, enough for the parity beat.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: after the FIFO_WIDTH data beats, one extra beat carries the even parity (XOR of all data bits). ser_last moves to the parity beat, so a word is FIFO_WIDTH+1 beats. The parity value is computed in LOAD.
- Undefined: no parity beat; ser_last is on data beat FIFO_WIDTH-1.

Test Plan:
- Reset: rst_n=0 at random time → all outputs 0 and state IDLE within the same cycle, no clock needed. Release, FIFO empty → fifo_rd_en stays 0 for 20 cycles.
- Single word: FIFO holds 16'hA5C3, enable=1, ser_ready=1, MSB_FIRST=1 → fifo_rd_en pulses 1 cycle. Two cycles later ser_data = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. ser_first on beat 0, ser_last on beat 15, words_sent=1.
- Back-pressure: word 16'h8000, ser_ready toggled 1/0 every cycle → 16 beats take 31 cycles from first valid. Bit 1 is held while ready=0; words_sent=1.
- Drain 8 words: FIFO full with the one-hot values 16'h0001..16'h0080 → exactly 8 rd_en pulses, each word serialized intact, 3-cycle gap between words, idle once fifo_empty=1. words_sent=8.
- Mid-word abort: reset asserted on beat 7 of 16'hFFFF → ser_valid=0 immediately, words_sent=0. After release with the FIFO holding 16'h0001, the next word is sent intact.
- Enable drop / parity: enable=0 at beat 3 → the word finishes and no further pop occurs. With SER_PARITY_EN, 16'h0007 → 17th beat = 1 carrying ser_last; 16'h0003 → parity beat = 0.
